// File: rtl/lieat_biu_rd_arbiter_pkg.sv
// Shared lieat defines: base word width, arbiter FSM encodings and requester indices.
package lieat_biu_rd_arbiter_pkg;
  localparam int XLEN = 32;

  // One-hot so an illegal pattern is easy to detect and flush back to IDLE.
  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_AR   = 3'b010,
    ST_R    = 3'b100
  } state_e;

  localparam logic REQ_IFU = 1'b0;
  localparam logic REQ_LSU = 1'b1;
endpackage

// File: rtl/lieat_biu_rd_arbiter_if.sv
// Read-bus bundle between the two requesters, the arbiter and the shared memory port.
interface lieat_biu_rd_arbiter_if #(
  parameter int AW = lieat_biu_rd_arbiter_pkg::XLEN,
  parameter int DW = 2 * lieat_biu_rd_arbiter_pkg::XLEN
);
  logic [AW-1:0] ifu_araddr;
  logic          ifu_arvalid;
  logic          ifu_arready;
  logic [DW-1:0] ifu_rdata;
  logic          ifu_rvalid;
  logic          ifu_rready;

  logic [AW-1:0] lsu_araddr;
  logic          lsu_arvalid;
  logic          lsu_arready;
  logic [DW-1:0] lsu_rdata;
  logic          lsu_rvalid;
  logic          lsu_rready;

  logic [AW-1:0] mem_araddr;
  logic          mem_arvalid;
  logic          mem_arready;
  logic [DW-1:0] mem_rdata;
  logic          mem_rvalid;
  logic          mem_rready;

  // Arbiter view.
  modport slave (
    input  ifu_araddr, ifu_arvalid, ifu_rready,
    input  lsu_araddr, lsu_arvalid, lsu_rready,
    input  mem_arready, mem_rdata, mem_rvalid,
    output ifu_arready, ifu_rdata, ifu_rvalid,
    output lsu_arready, lsu_rdata, lsu_rvalid,
    output mem_araddr, mem_arvalid, mem_rready
  );

  // Requester + memory environment view.
  modport master (
    output ifu_araddr, ifu_arvalid, ifu_rready,
    output lsu_araddr, lsu_arvalid, lsu_rready,
    output mem_arready, mem_rdata, mem_rvalid,
    input  ifu_arready, ifu_rdata, ifu_rvalid,
    input  lsu_arready, lsu_rdata, lsu_rvalid,
    input  mem_araddr, mem_arvalid, mem_rready
  );
endinterface

// File: rtl/lieat_biu_rd_arbiter_arb.sv
// General primitives: two-way round-robin pick and reset-valued flop.
module lieat_general_rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);
  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = last_i ? 2'b01 : 2'b10;
        default: gnt_o = 2'b00;
      endcase
    end
  end
endmodule

module lieat_general_dffr #(
  parameter int           W   = 1,
  parameter logic [W-1:0] RST = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= RST;
    else        q <= d;
  end
endmodule

// File: rtl/lieat_biu_rd_arbiter.sv
// Two-requester (IFU/LSU) read arbiter onto a single memory read port, one outstanding read.
module lieat_biu_rd_arbiter
  import lieat_biu_rd_arbiter_pkg::*;
#(
  parameter int AW = XLEN,
  parameter int DW = 2 * XLEN
) (
  input  logic                    clock,
  input  logic                    reset,
  lieat_biu_rd_arbiter_if.slave   bus
);
  logic [2:0]    state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [1:0]    gnt;
  logic          st_idle, st_ar, st_r, own_rready;

  assign st_idle    = (state_q == ST_IDLE);
  assign st_ar      = (state_q == ST_AR);
  assign st_r       = (state_q == ST_R);
  assign own_rready = (owner_q == REQ_LSU) ? bus.lsu_rready : bus.ifu_rready;

  // Gate on reset so no arready leaks out while the block is held in reset.
  lieat_general_rr_arb2 u_rr (
    .req_i  ({bus.lsu_arvalid, bus.ifu_arvalid}),
    .last_i (last_q),
    .en_i   (st_idle & reset),
    .gnt_o  (gnt)
  );

  lieat_general_dffr #(.W(3), .RST(ST_IDLE)) u_state (.clk(clock), .rst_n(reset), .d(state_d), .q(state_q));
  lieat_general_dffr #(.W(1), .RST(REQ_IFU)) u_owner (.clk(clock), .rst_n(reset), .d(owner_d), .q(owner_q));
  lieat_general_dffr #(.W(1), .RST(REQ_LSU)) u_last  (.clk(clock), .rst_n(reset), .d(last_d),  .q(last_q));
  lieat_general_dffr #(.W(AW), .RST('0))     u_addr  (.clk(clock), .rst_n(reset), .d(addr_d),  .q(addr_q));

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: if (|gnt) begin
        state_d = ST_AR;
        owner_d = gnt[1];
        addr_d  = gnt[1] ? bus.lsu_araddr : bus.ifu_araddr;
      end
      ST_AR: if (bus.mem_arready) state_d = ST_R;
      ST_R: if (bus.mem_rvalid && own_rready) begin
        state_d = ST_IDLE;
        last_d  = owner_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.ifu_arready = gnt[0];
    bus.lsu_arready = gnt[1];
    bus.mem_arvalid = st_ar;
    bus.mem_araddr  = st_ar ? addr_q : '0;
    bus.mem_rready  = st_r & own_rready;
    bus.ifu_rvalid  = 1'b0;
    bus.ifu_rdata   = '0;
    bus.lsu_rvalid  = 1'b0;
    bus.lsu_rdata   = '0;
    if (st_r) begin
      if (owner_q == REQ_LSU) begin
        bus.lsu_rvalid = bus.mem_rvalid;
        bus.lsu_rdata  = bus.mem_rdata;
      end else begin
        bus.ifu_rvalid = bus.mem_rvalid;
        bus.ifu_rdata  = bus.mem_rdata;
      end
    end
  end
endmodule

// File: tb/tb_lieat_biu_rd_arbiter.sv
// Cycle-table bench for the IFU/LSU read arbiter, plus a hand sequence for reset mid-AR.
module tb_lieat_biu_rd_arbiter;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam logic [63:0] D1 = 64'hDEAD_BEEF_0000_0001;
  localparam logic [63:0] D2 = 64'h1122_3344_5566_7788;
  localparam logic [63:0] D3 = 64'hCAFE_F00D_1234_5678;

  typedef struct packed {
    logic iv; logic [AW-1:0] ia; logic lv; logic [AW-1:0] la;
    logic mar; logic mrv; logic [DW-1:0] md; logic irr; logic lrr;
  } in_t;

  typedef struct packed {
    logic iar; logic lar; logic mav; logic [AW-1:0] maa; logic mrr;
    logic irv; logic lrv; logic [DW-1:0] ird; logic [DW-1:0] lrd;
  } out_t;

  typedef struct {
    string nm;
    in_t   i;
    out_t  o;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  vec_t tbl[$];

  lieat_biu_rd_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  lieat_biu_rd_arbiter #(.AW(AW), .DW(DW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic in_t mi(bit iv, logic [31:0] ia, bit lv, logic [31:0] la,
                             bit mar, bit mrv, logic [63:0] md, bit irr, bit lrr);
    return in_t'{iv, ia, lv, la, mar, mrv, md, irr, lrr};
  endfunction

  function automatic out_t mo(bit iar, bit lar, bit mav, logic [31:0] maa, bit mrr,
                              bit irv, bit lrv, logic [63:0] ird, logic [63:0] lrd);
    return out_t'{iar, lar, mav, maa, mrr, irv, lrv, ird, lrd};
  endfunction

  function automatic void add(string nm, in_t i, out_t o);
    vec_t v;
    v.nm = nm; v.i = i; v.o = o;
    tbl.push_back(v);
  endfunction

  task automatic drive(in_t v);
    bus.ifu_arvalid = v.iv;  bus.ifu_araddr = v.ia;  bus.ifu_rready = v.irr;
    bus.lsu_arvalid = v.lv;  bus.lsu_araddr = v.la;  bus.lsu_rready = v.lrr;
    bus.mem_arready = v.mar; bus.mem_rvalid = v.mrv; bus.mem_rdata  = v.md;
  endtask

  task automatic chk(string nm, out_t exp);
    out_t got;
    got = out_t'{bus.ifu_arready, bus.lsu_arready, bus.mem_arvalid, bus.mem_araddr,
                 bus.mem_rready, bus.ifu_rvalid, bus.lsu_rvalid, bus.ifu_rdata, bus.lsu_rdata};
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  initial begin
    // Simultaneous requests from reset: IFU, LSU, IFU; memory always ready.
    add("tie_ifu",  mi(1,32'h100,1,32'h200,1,1,D1,1,1), mo(1,0,0,0,0,0,0,0,0));
    add("tie_ar0",  mi(1,32'h100,1,32'h200,1,1,D1,1,1), mo(0,0,1,32'h100,0,0,0,0,0));
    add("tie_r0",   mi(1,32'h100,1,32'h200,1,1,D1,1,1), mo(0,0,0,0,1,1,0,D1,0));
    add("tie_lsu",  mi(1,32'h100,1,32'h200,1,1,D1,1,1), mo(0,1,0,0,0,0,0,0,0));
    add("tie_ar1",  mi(1,32'h100,1,32'h200,1,1,D1,1,1), mo(0,0,1,32'h200,0,0,0,0,0));
    add("tie_r1",   mi(1,32'h100,1,32'h200,1,1,D1,1,1), mo(0,0,0,0,1,0,1,0,D1));
    add("tie_ifu2", mi(1,32'h100,1,32'h200,1,1,D1,1,1), mo(1,0,0,0,0,0,0,0,0));
    add("tie_ar2",  mi(0,0,0,0,1,1,D1,1,1),             mo(0,0,1,32'h100,0,0,0,0,0));
    add("tie_r2",   mi(0,0,0,0,1,1,D1,1,1),             mo(0,0,0,0,1,1,0,D1,0));
    // Single IFU read with arvalid dropped after acceptance.
    add("ifu_acc",  mi(1,32'h8000_0010,0,0,0,0,0,1,1),  mo(1,0,0,0,0,0,0,0,0));
    add("ifu_ar1",  mi(0,0,0,0,0,0,0,1,1),              mo(0,0,1,32'h8000_0010,0,0,0,0,0));
    add("ifu_ar2",  mi(0,0,0,0,1,0,0,1,1),              mo(0,0,1,32'h8000_0010,0,0,0,0,0));
    add("ifu_r",    mi(0,0,0,0,0,0,0,1,1),              mo(0,0,0,0,1,0,0,0,0));
    add("ifu_data", mi(0,0,0,0,0,1,D2,1,1),             mo(0,0,0,0,1,1,0,D2,0));
    add("ifu_idle", mi(0,0,0,0,0,0,0,1,1),              mo(0,0,0,0,0,0,0,0,0));
    // LSU read with address and data backpressure.
    add("bp_acc",   mi(0,0,1,32'hA000_0040,0,0,0,1,1),  mo(0,1,0,0,0,0,0,0,0));
    for (int k = 0; k < 5; k++)
      add($sformatf("bp_ar%0d", k), mi(0,0,0,0,0,0,0,1,1), mo(0,0,1,32'hA000_0040,0,0,0,0,0));
    add("bp_arhs",  mi(0,0,0,0,1,0,0,1,1),              mo(0,0,1,32'hA000_0040,0,0,0,0,0));
    for (int k = 0; k < 3; k++)
      add($sformatf("bp_rw%0d", k), mi(0,0,0,0,0,1,D3,1,0), mo(0,0,0,0,0,0,1,0,D3));
    add("bp_rdone", mi(0,0,0,0,0,1,D3,1,1),             mo(0,0,0,0,1,0,1,0,D3));
    add("bp_once",  mi(0,0,0,0,0,1,D3,1,1),             mo(0,0,0,0,0,0,0,0,0));
    // LSU request arriving while IFU is in flight.
    add("dr_acc",   mi(1,32'h300,0,0,0,0,0,1,1),        mo(1,0,0,0,0,0,0,0,0));
    add("dr_ar",    mi(0,0,1,32'h400,1,0,0,1,1),        mo(0,0,1,32'h300,0,0,0,0,0));
    add("dr_rw",    mi(0,0,1,32'h400,0,0,0,1,1),        mo(0,0,0,0,1,0,0,0,0));
    add("dr_rdone", mi(0,0,1,32'h400,0,1,D1,1,1),       mo(0,0,0,0,1,1,0,D1,0));
    add("dr_lsu",   mi(0,0,1,32'h400,0,0,0,1,1),        mo(0,1,0,0,0,0,0,0,0));
    add("dr_ar2",   mi(0,0,0,0,1,0,0,1,1),              mo(0,0,1,32'h400,0,0,0,0,0));
    add("dr_r2",    mi(0,0,0,0,0,1,D2,1,1),             mo(0,0,0,0,1,0,1,0,D2));
    add("dr_idle",  mi(0,0,0,0,0,0,0,1,1),              mo(0,0,0,0,0,0,0,0,0));
    // IFU served last, then LSU parked in AR for the reset sequence.
    add("rs_acc",   mi(1,32'h500,0,0,1,0,0,1,1),        mo(1,0,0,0,0,0,0,0,0));
    add("rs_ar",    mi(0,0,0,0,1,0,0,1,1),              mo(0,0,1,32'h500,0,0,0,0,0));
    add("rs_r",     mi(0,0,0,0,0,1,D3,1,1),             mo(0,0,0,0,1,1,0,D3,0));
    add("rs_lsu",   mi(0,0,1,32'h540,0,0,0,1,1),        mo(0,1,0,0,0,0,0,0,0));

    drive(mi(1,32'h100,1,32'h200,1,1,D1,1,1));
    repeat (2) @(posedge clock);
    #1 chk("reset_hold", mo(0,0,0,0,0,0,0,0,0));
    drive(mi(0,0,0,0,0,0,0,1,1));
    @(negedge clock) reset = 1'b1;
    @(posedge clock) #1;

    foreach (tbl[n]) begin
      drive(tbl[n].i);
      @(negedge clock);
      chk(tbl[n].nm, tbl[n].o);
      @(posedge clock) #1;
    end

    // Now in AR for LSU 0x540 with IFU as last-served.
    drive(mi(0,0,0,0,0,0,0,1,1));
    #1 chk("rst_pre", mo(0,0,1,32'h540,0,0,0,0,0));
    reset = 1'b0;
    #1 chk("rst_async", mo(0,0,0,0,0,0,0,0,0));
    drive(mi(1,32'h600,1,32'h700,0,0,0,1,1));
    #1 chk("rst_noready", mo(0,0,0,0,0,0,0,0,0));
    @(posedge clock);
    @(negedge clock) reset = 1'b1;
    #1 chk("rst_rr_ifu", mo(1,0,0,0,0,0,0,0,0));
    @(posedge clock) #1;
    chk("rst_ar_ifu", mo(0,0,1,32'h600,0,0,0,0,0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
